// File: rtl/strokie_alu_driver.sv
// strokie_alu_driver: initiator for the strokie ALU operand/result interface.
// Commands are queued in a small FIFO and issued one at a time. The ALU pins
// are registered at pop. When the ALU reports ready, or when the timeout
// expires, the result is held on a valid/ready result channel.
module strokie_alu_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_mode,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  output logic        alu_mode_fp,
  input  logic [31:0] alu_q,
  input  logic        alu_ready,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        mode;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            alu_mode_q, alu_mode_d;
  logic [31:0]     res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic            res_valid_q, res_valid_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  cmd_t            head;
  cmd_t            wr_cmd;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = cmd_valid & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op, mode: cmd_mode};

  assign cmd_ready   = ~full;
  assign busy        = (state_q != S_IDLE) | ~empty;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_mode_fp = alu_mode_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_err     = res_err_q;

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_cmd;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue/wait/return sequencing, ALU pin and result register next-state.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_mode_d  = alu_mode_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          // fp16 operands sit in the upper half-word of the ALU inputs.
          alu_a_d    = head.mode ? head.a : {head.a[15:0], 16'h0000};
          alu_b_d    = head.mode ? head.b : {head.b[15:0], 16'h0000};
          alu_op_d   = head.op;
          alu_mode_d = head.mode;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_ready) begin
          res_data_d  = alu_mode_q ? alu_q : {16'h0000, alu_q[31:16]};
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_mode_q  <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_mode_q  <= alu_mode_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_strokie_alu_driver.sv
// Bench for strokie_alu_driver: directed scenarios followed by a randomized
// run, with a queue-based reference model and a stub ALU.
module tb_strokie_alu_driver;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic        cmd_mode = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_mode_fp;
  logic [31:0] alu_q;
  logic        alu_ready;
  logic        busy;

  logic        stub_fixed = 1'b1;
  logic [31:0] stub_val = '0;
  logic        stub_rdy = 1'b1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  // Stub ALU: deterministic mixing function of its pins, or a fixed value.
  function automatic logic [31:0] stub_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  assign alu_q     = stub_fixed ? stub_val : stub_fn(alu_a, alu_b, alu_op);
  assign alu_ready = stub_rdy;

  strokie_alu_driver #(.DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mode_fp(alu_mode_fp),
    .alu_q(alu_q), .alu_ready(alu_ready), .busy(busy)
  );

  function automatic logic [31:0] pack(input logic [31:0] v, input logic m);
    return m ? v : {v[15:0], 16'h0000};
  endfunction

  // Expected {err, data} for a command run through the stub ALU.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic m);
    logic [31:0] q;
    q = stub_fn(pack(a, m), pack(b, m), op);
    return {1'b0, (m ? q : {16'h0000, q[31:16]})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic m);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = m;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic m);
    set_cmd(a, b, op, m);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare with the model queue, then accept it.
  task automatic take_result(input string tag);
    logic [32:0] e;
    for (int k = 0; k < 100 && !res_valid; k++) tick();
    check({tag, " valid"}, 32'(res_valid), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
    check({tag, " data"}, res_data, e[31:0]);
    check({tag, " err"}, 32'(res_err), 32'(e[32]));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, " valid drop"}, 32'(res_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " res_valid"}, 32'(res_valid), 32'd0);
    check({tag, " res_data"}, res_data, 32'd0);
    check({tag, " res_err"}, 32'(res_err), 32'd0);
    check({tag, " alu_a"}, alu_a, 32'd0);
    check({tag, " alu_b"}, alu_b, 32'd0);
    check({tag, " alu_op"}, 32'(alu_op), 32'd0);
    check({tag, " alu_mode"}, 32'(alu_mode_fp), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic        rm;
    int unsigned sent;
    int unsigned low_streak;
    bit          acc_cmd, acc_res;
    logic [32:0] e;

    // Reset state
    #23;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // fp32 add with fixed stub result, latency 3 edges after the push
    stub_fixed = 1'b1; stub_val = 32'h40400000; stub_rdy = 1'b1;
    push_one(32'h3F800000, 32'h40000000, 2'b00, 1'b1);
    check("fp32 busy", 32'(busy), 32'd1);
    check("fp32 lat0", 32'(res_valid), 32'd0);
    tick();
    check("fp32 alu_a", alu_a, 32'h3F800000);
    check("fp32 alu_b", alu_b, 32'h40000000);
    check("fp32 mode", 32'(alu_mode_fp), 32'd1);
    check("fp32 op", 32'(alu_op), 32'd0);
    tick();
    check("fp32 lat2", 32'(res_valid), 32'd0);
    tick();
    check("fp32 lat3", 32'(res_valid), 32'd1);
    exp_q.push_back({1'b0, 32'h40400000});
    take_result("fp32");
    check("fp32 idle busy", 32'(busy), 32'd0);

    // fp16 add: operands packed high, result unpacked low
    stub_val = 32'h42000000;
    push_one(32'h00003C00, 32'h00004000, 2'b00, 1'b0);
    tick();
    check("fp16 alu_a", alu_a, 32'h3C000000);
    check("fp16 alu_b", alu_b, 32'h40000000);
    check("fp16 mode", 32'(alu_mode_fp), 32'd0);
    exp_q.push_back({1'b0, 32'h00004200});
    take_result("fp16");

    // Five back-to-back pushes with the consumer stalled
    stub_fixed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 32'h1000_0000 * (i + 1) + 32'h55; rb = 32'hA5A5_0000 + 32'(i);
      rop = 2'(i); rm = 1'(i & 1);
      check("fill ready", 32'(cmd_ready), 32'd1);
      exp_q.push_back(model(ra, rb, rop, rm));
      push_one(ra, rb, rop, rm);
    end
    check("full ready", 32'(cmd_ready), 32'd0);
    check("full busy", 32'(busy), 32'd1);
    set_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1);
    cmd_valid = 1'b1;
    tick(); tick(); tick();
    cmd_valid = 1'b0;

    // Backpressure: result and ALU pins stay put for 10 cycles
    check("bp valid", 32'(res_valid), 32'd1);
    held = res_data;
    check("bp first", held, exp_q[0][31:0]);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp data stable", res_data, held);
      check("bp no pop", alu_a, pack(32'h1000_0055, 1'b0));
      check("bp ready low", 32'(cmd_ready), 32'd0);
    end
    for (int i = 0; i < 5; i++) take_result("drain");
    check("drain busy", 32'(busy), 32'd0);

    // Timeout: ALU never ready
    stub_rdy = 1'b0;
    push_one(32'h1234_5678, 32'h9ABC_DEF0, 2'b01, 1'b1);
    for (int k = 1; k <= int'(TMO) + 1; k++) begin
      tick();
      check("tmo early", 32'(res_valid), 32'd0);
    end
    tick();
    check("tmo valid", 32'(res_valid), 32'd1);
    check("tmo err", 32'(res_err), 32'd1);
    check("tmo data", res_data, 32'd0);
    stub_rdy = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    take_result("tmo");
    exp_q.push_back(model(32'h0BAD_F00D, 32'h0000_1111, 2'b10, 1'b1));
    push_one(32'h0BAD_F00D, 32'h0000_1111, 2'b10, 1'b1);
    take_result("post tmo");

    // Randomized traffic with random ALU ready and consumer stalls
    sent = 0; low_streak = 0;
    for (int cyc = 0; cyc < 3000 && (sent < 40 || exp_q.size() > 0); cyc++) begin
      if (low_streak >= 3) stub_rdy = 1'b1;
      else stub_rdy = 1'($urandom_range(0, 1));
      low_streak = stub_rdy ? 0 : low_streak + 1;
      if (!cmd_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
        set_cmd($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        cmd_valid = 1'b1;
      end
      res_ready = 1'($urandom_range(0, 1));
      acc_cmd = cmd_valid && cmd_ready;
      acc_res = res_valid && res_ready;
      if (acc_res) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
        check("rand data", res_data, e[31:0]);
        check("rand err", 32'(res_err), 32'(e[32]));
      end
      if (acc_cmd) begin
        exp_q.push_back(model(cmd_a, cmd_b, cmd_op, cmd_mode));
        sent++;
      end
      tick();
      if (acc_cmd) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;
    check("rand sent", sent, 32'd40);
    check("rand drained", exp_q.size(), 32'd0);

    // Reset asserted while waiting on the ALU
    stub_rdy = 1'b0;
    push_one(32'h7777_7777, 32'h3333_3333, 2'b11, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst wait");
    #3;
    rst = 1'b0;
    stub_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no stale", 32'(res_valid), 32'd0);
      check("no stale busy", 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
